// File: rtl/muldiv_sequencer.sv
// HI/LO multi-cycle unit: iterative shift-add multiply and restoring divide,
// plus MTHI/MTLO writes and the fetch stall for requests colliding with an op in flight.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;
    // w_lo holds the multiplier (shifted out LSB first) and collects product low bits
    mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
    // w_hi is the partial remainder, w_lo shifts dividend bits out and quotient bits in
    div_sh    = {w_hi, w_lo[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, opnd});
    div_diff  = div_sh - {1'b0, opnd};
    prod_fix  = neg_q ? ('0 - {w_hi, w_lo}) : {w_hi, w_lo};
    q_fix     = neg_q ? ('0 - w_lo) : w_lo;
    r_fix     = neg_r ? ('0 - w_hi) : w_hi;
    stall     = busy & (start | mf_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      w_hi     <= '0;
      w_lo     <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                w_hi     <= '0;
                w_lo     <= a_mag;
                opnd     <= b_mag;
                a_raw    <= a;
                is_div   <= op[1];
                neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= op_signed & a[WIDTH-1];
                div_zero <= (b == '0);
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= S_RUN;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (is_div) begin
            w_hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            w_lo <= {w_lo[WIDTH-2:0], div_ge};
          end else begin
            {w_hi, w_lo} <= {mul_sum, w_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed table, collision/reset sequences and
// random ops checked against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mf_req = 1'b0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: arithmetic on 64-bit values, SV / and % truncate toward zero.
  task automatic model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      3'd0: begin sp = sa * sb; {m_hi, m_lo} = sp; end
      3'd1: begin up = {32'd0, ma} * {32'd0, mb}; {m_hi, m_lo} = up; end
      3'd2, 3'd3: begin
        if (mb == 0) begin
          m_hi = ma; m_lo = '1;
        end else if (mop == 3'd2) begin
          sp = sa / sb; m_lo = sp[31:0];
          sp = sa % sb; m_hi = sp[31:0];
        end else begin
          m_lo = ma / mb; m_hi = ma % mb;
        end
      end
      3'd4: m_hi = ma;
      3'd5: m_lo = ma;
      default: ;
    endcase
  endtask

  // Caller is at a negedge; returns #1 after the accepting posedge.
  task automatic issue(input logic [2:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    start = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts busy negedges until done; returns at the done-cycle negedge.
  task automatic wait_result(input string name, input int exp_n,
                             input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    logic moved;
    logic [W-1:0] h0, l0;
    n = 0; moved = 1'b0; h0 = hi; l0 = lo;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) n++;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
    end
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " latency"}, 64'(n), 64'(exp_n));
    chk({name, " hilo stable in run"}, 64'(moved), 64'd0);
    chk({name, " busy in done cycle"}, 64'(busy), 64'd0);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{3'd1, 32'd0,        32'h12345678, 32'd0,        32'd0};

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);
    chk("reset stall", 64'(stall), 0);
    chk("reset hi", 64'(hi), 0);
    chk("reset lo", 64'(lo), 0);

    // directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), W + 1, vecs[i].exp_hi, vecs[i].exp_lo);
      model(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 64'(done), 0);
    end

    // back-to-back start accepted in the done cycle
    @(negedge clk);
    issue(3'd1, 32'd9, 32'd9);
    wait_result("b2b first", W + 1, 32'd0, 32'd81);
    issue(3'd3, 32'd50, 32'd8);
    wait_result("b2b second", W + 1, 32'd2, 32'd6);
    model(3'd3, 32'd50, 32'd8);

    // collisions during RUN: stall, no relatch
    @(negedge clk);
    issue(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd99; b = 32'd99;
    #1 chk("stall on start", 64'(stall), 1);
    @(negedge clk);
    #1 chk("stall on start held", 64'(stall), 1);
    start = 1'b0; mf_req = 1'b1;
    #1 chk("stall on mf_req", 64'(stall), 1);
    @(negedge clk);
    mf_req = 1'b0;
    #1 chk("no stall when idle inputs", 64'(stall), 0);
    wait_result("collide", W + 1 - 3, 32'd0, 32'd15);
    model(3'd1, 32'd3, 32'd5);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    mf_req = 1'b1;
    #1 chk("no stall mf_req idle", 64'(stall), 0);
    mf_req = 1'b0;
    issue(3'd4, 32'h1234, 32'd0);
    model(3'd4, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi busy", 64'(busy), 0);
    chk("mthi done", 64'(done), 0);
    issue(3'd5, 32'hCAFE, 32'd0);
    model(3'd5, 32'hCAFE, 32'd0);
    @(negedge clk);
    chk("mtlo lo", 64'(lo), 64'hCAFE);
    chk("mtlo hi kept", 64'(hi), 64'h1234);

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [2:0] rop;
      logic [W-1:0] ra, rb;
      int sel;
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      sel = $urandom_range(0, 3);
      rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 1) ra = ra >> $urandom_range(0, 31);
      @(negedge clk);
      issue(rop, ra, rb);
      model(rop, ra, rb);
      if (rop <= 3'd3) begin
        wait_result($sformatf("rand%0d op%0d", i, rop), W + 1, m_hi, m_lo);
      end else begin
        @(negedge clk);
        chk($sformatf("rand%0d op%0d busy", i, rop), 64'(busy), 0);
        chk($sformatf("rand%0d op%0d hi", i, rop), 64'(hi), 64'(m_hi));
        chk($sformatf("rand%0d op%0d lo", i, rop), 64'(lo), 64'(m_lo));
      end
    end

    // reset mid-RUN aborts with no done pulse
    @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 0);
    chk("abort hi", 64'(hi), 0);
    chk("abort lo", 64'(lo), 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("abort no done", 64'(seen), 0);
    end
    issue(3'd1, 32'd6, 32'd7);
    wait_result("after abort", W + 1, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
